melody_recorder: RTL and testbench
==================================

# melody_recorder

Record-and-playback stage between `piano_keypad` and `pitch_generator`. In idle and record modes it forwards the live `{note, octave}` from the keypad to the tone generator. While recording, it stores each held note or rest as an event with a duration measured in ticks. In play mode it replays the stored events to `pitch_generator` with the same timing.

## Interface
Parameters:
- `DEPTH`, 64 — event buffer entries; power of two.
- `DUR_W`, 12 — duration field width in ticks; saturates at 2^DUR_W−1.

Ports:
- `clk` in 1 — system clock; all logic is on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `tick` in 1 — one-cycle timebase strobe (1 kHz in the top level).
- `note_in` in 4 — live note from `piano_keypad`; 0 = rest.
- `octave_in` in 4 — live octave from `piano_keypad`.
- `rec` in 1 — one-cycle pulse: start recording.
- `play` in 1 — one-cycle pulse: start playback.
- `stop` in 1 — one-cycle pulse: abort the current mode.
- `note_out` out 4 — note to `pitch_generator`; registered.
- `octave_out` out 4 — octave to `pitch_generator`; registered.
- `busy` out 1 — high while the state is not IDLE.
- `full` out 1 — high when the buffer holds DEPTH events.
- `done` out 1 — one-cycle pulse at the end of playback (or at each wrap; see Configuration).
- `count` out log2(DEPTH)+1 — number of stored events.

## Operation
- States:
  - IDLE: `note_out`/`octave_out` follow the live inputs.
  - REC: as IDLE for the outputs, plus event capture.
  - LOAD: one-cycle RAM read.
  - PLAY: output the current event.
- Command priority is `stop` > `rec` > `play`, evaluated every cycle.
- IDLE transitions:
  - `rec` → REC. `count` clears to 0, `full` clears. `cur_code` is loaded with `{note_in, octave_in}` and `cur_dur` with 0.
  - `play` with `count`≠0 → LOAD, with `rd_ptr` at 0.
  - `play` with `count`=0 → ignored.
- REC, evaluated every cycle:
  - If the input code differs from `cur_code` and `cur_dur`≠0: commit `{cur_code, cur_dur}` to `mem[count]`, then increment `count`. Independently, load `cur_code` with the new input and `cur_dur` with 0.
  - If the input code differs and `cur_dur`=0: the pending event is discarded without a write.
  - If the input code is unchanged and `tick` is high: `cur_dur` increments, saturating at 2^DUR_W−1.
  - If a code change and `tick` occur in the same cycle, the change wins and the tick is dropped.
  - When a commit makes `count` reach DEPTH: `full` is set and the state goes to IDLE.
  - On `stop`: the pending event is committed if `cur_dur`≠0 and the buffer is not full, then the state goes to IDLE.
  - `play` is ignored in REC.
- LOAD:
  - `note_out` and `octave_out` are forced to 0, producing a one-cycle rest.
  - The registered RAM output is latched; `remaining` is loaded with the entry's duration.
  - Next state is PLAY.
- PLAY:
  - The outputs drive the latched entry's note and octave.
  - `tick` decrements `remaining`.
  - A `tick` while `remaining`=1 ends the entry:
    - If `rd_ptr` < `count`−1: `rd_ptr` increments and the state goes to LOAD.
    - Otherwise: end-of-melody (see Configuration).
  - `stop` → IDLE, with the outputs reverting to live input on the next cycle.
  - `rec` is ignored in PLAY.
- Reset values: state IDLE; `note_out`, `octave_out`, `count`, `busy`, `full`, `done` all 0; buffer contents are not cleared.

## Timing
- Pass-through latency is 1 clk: input change → `note_out`.
- Playback start: the `play` pulse → LOAD on the next edge → entry note on `note_out` 2 clks after the pulse.
- An entry with duration d is output for exactly d ticks, plus the 1-clk LOAD rest.
- The commit write occurs in the same clk as the detected code change.
- `count` updates 1 clk after the change is sampled.
- `done` is asserted for exactly 1 clk, coincident with the state leaving PLAY on the final tick.
- `busy` is combinational from the state register.

## Configuration
- `MELODY_LOOP_EN` defined:
  - At end-of-melody, `rd_ptr` wraps to 0, the state goes to LOAD, and `done` pulses.
  - Playback repeats until `stop`.
- `MELODY_LOOP_EN` undefined:
  - At end-of-melody, the state goes to IDLE and `done` pulses.

## Structure
- Package `melody_pkg` contains:
  - State enum `{IDLE, REC, LOAD, PLAY}`.
  - `NOTE_REST` = 4'd0.
  - Event width = 8 + DUR_W.
  - A packed event struct `{note, octave, dur}`.
- Sub-module `melody_ram`: DEPTH × (8+DUR_W), one synchronous write port, one synchronous read port with 1-clk read latency, no reset.
- Top-level FSM, duration counter, and output mux live in `melody_recorder`.

## Test plan
- **Pass-through:** in IDLE, drive note 5 / octave 4 → `note_out`=5, `octave_out`=4 one clk later; `busy`=0.
- **Record and play:** `rec`, then hold note 1 for 3 ticks, note 3 for 2 ticks, rest for 1 tick, then `stop` → `count`=3. Then `play` → outputs are note 1 for 3 ticks, note 3 for 2 ticks, note 0 for 1 tick, then one `done` pulse, then IDLE.
- **Short-event drop:** change note twice within one tick interval during REC → no commit for the zero-duration event; `count` is unchanged.
- **Fill:** with DEPTH=4, record 5 distinct notes of 1 tick each → `full`=1 and the state returns to IDLE after the 4th commit; `count`=4.
- **Priority and guards:**
  - `play` with `count`=0 → stays IDLE.
  - `rec` and `stop` in the same cycle during PLAY → IDLE.
  - `rec` during PLAY → ignored.
- **Reset mid-play:** assert `rst` during PLAY → next clk state is IDLE, outputs 0, `count`=0. With `MELODY_LOOP_EN` defined, a 2-entry playback wraps and `done` pulses once per pass.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared state encoding, event layout and constants for the melody recorder.
package melody_pkg;

    typedef enum logic [1:0] {IDLE, REC, LOAD, PLAY} state_t;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam int DUR_W_DEF = 12;

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] octave;
    } code_t;

    // Stored event layout at the default duration width; the buffer keeps the same field order.
    typedef struct packed {
        logic [3:0]           note;
        logic [3:0]           octave;
        logic [DUR_W_DEF-1:0] dur;
    } event_t;

    function automatic int event_width(input int dur_w);
        return 8 + dur_w;
    endfunction

endpackage

// File: rtl/melody_recorder_if.sv
// Keypad-side inputs and pitch-generator-side outputs of melody_recorder.
interface melody_recorder_if #(
    parameter int DEPTH = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             tick;
    logic [3:0]       note_in;
    logic [3:0]       octave_in;
    logic             rec;
    logic             play;
    logic             stop;
    logic [3:0]       note_out;
    logic [3:0]       octave_out;
    logic             busy;
    logic             full;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output tick, note_in, octave_in, rec, play, stop,
        input  note_out, octave_out, busy, full, done, count
    );

    modport slave (
        input  tick, note_in, octave_in, rec, play, stop,
        output note_out, octave_out, busy, full, done, count
    );

endinterface

// File: rtl/melody_ram.sv
// Event buffer: one synchronous write port, one registered read port, contents not reset.
module melody_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/melody_recorder.sv
// Record/playback stage between piano_keypad and pitch_generator.
// Define MELODY_LOOP_EN to repeat playback until stop instead of returning to IDLE.
//
// state | meaning
// IDLE  | outputs follow live keypad input
// REC   | live pass-through while capturing note/rest events
// LOAD  | one-cycle rest while the next event is read from the buffer
// PLAY  | drive the stored event until its duration in ticks elapses
module melody_recorder
    import melody_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DUR_W = 12
) (
    input logic              clk,
    input logic              rst,
    melody_recorder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = event_width(DUR_W);
    localparam logic [DUR_W-1:0] DUR_MAX  = {DUR_W{1'b1}};
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);

    state_t           r_state;
    code_t            r_cur_code;
    code_t            r_play_code;
    code_t            w_live;
    logic [DUR_W-1:0] r_cur_dur;
    logic [DUR_W-1:0] r_remaining;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_inc;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic             r_full;
    logic             r_done;
    logic [3:0]       r_note_out;
    logic [3:0]       r_octave_out;
    logic             w_changed;
    logic             w_pending;
    logic             w_commit;
    logic             w_fill;
    logic             w_entry_end;
    logic             w_last;
    logic [EW-1:0]    w_rdata;

    assign w_live      = {bus.note_in, bus.octave_in};
    assign w_changed   = w_live != r_cur_code;
    assign w_pending   = r_cur_dur != '0;
    // A stop commits the pending event; otherwise only a code change does.
    assign w_commit    = (r_state == REC) && w_pending && (bus.stop ? !r_full : w_changed);
    assign w_count_inc = r_count + 1'b1;
    assign w_fill      = w_commit && (w_count_inc == CNT_FULL);
    assign w_entry_end = (r_state == PLAY) && bus.tick && (r_remaining == DUR_W'(1));
    assign w_last      = (({1'b0, r_rd_ptr} + 1'b1) == r_count);

    // The read address leads the pointer so the entry is ready during LOAD.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (r_state == IDLE) begin
            w_rd_ptr_nxt = '0;
        end else if (w_entry_end) begin
            if (!w_last) begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
`ifdef MELODY_LOOP_EN
            else begin
                w_rd_ptr_nxt = '0;
            end
`endif
        end
    end

    melody_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_count[AW-1:0]),
        .i_wdata ({r_cur_code, r_cur_dur}),
        .i_raddr (w_rd_ptr_nxt),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_note_out   <= '0;
            r_octave_out <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_done       <= 1'b0;
            r_cur_code   <= '0;
            r_cur_dur    <= '0;
            r_play_code  <= '0;
            r_remaining  <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_done                     <= 1'b0;
            r_rd_ptr                   <= w_rd_ptr_nxt;
            {r_note_out, r_octave_out} <= w_live;
            if (w_commit) begin
                r_count <= w_count_inc;
            end
            case (r_state)
                IDLE: begin
                    if (!bus.stop && bus.rec) begin
                        r_state    <= REC;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_cur_code <= w_live;
                        r_cur_dur  <= '0;
                    end else if (!bus.stop && bus.play && (r_count != '0)) begin
                        r_state                    <= LOAD;
                        {r_note_out, r_octave_out} <= {NOTE_REST, 4'd0};
                    end
                end
                REC: begin
                    if (bus.stop || w_fill) begin
                        r_state <= IDLE;
                    end
                    if (w_fill) begin
                        r_full <= 1'b1;
                    end
                    if (w_changed) begin
                        r_cur_code <= w_live;
                        r_cur_dur  <= '0;
                    end else if (bus.tick && (r_cur_dur != DUR_MAX)) begin
                        r_cur_dur <= r_cur_dur + 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                    end else begin
                        r_state                    <= PLAY;
                        r_play_code                <= w_rdata[EW-1 -: 8];
                        r_remaining                <= w_rdata[DUR_W-1:0];
                        {r_note_out, r_octave_out} <= w_rdata[EW-1 -: 8];
                    end
                end
                PLAY: begin
                    {r_note_out, r_octave_out} <= r_play_code;
                    if (bus.stop) begin
                        r_state                    <= IDLE;
                        {r_note_out, r_octave_out} <= w_live;
                    end else if (w_entry_end) begin
                        if (!w_last) begin
                            r_state                    <= LOAD;
                            {r_note_out, r_octave_out} <= {NOTE_REST, 4'd0};
                        end else begin
                            r_done <= 1'b1;
`ifdef MELODY_LOOP_EN
                            r_state                    <= LOAD;
                            {r_note_out, r_octave_out} <= {NOTE_REST, 4'd0};
`else
                            r_state                    <= IDLE;
                            {r_note_out, r_octave_out} <= w_live;
`endif
                        end
                    end else if (bus.tick) begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.note_out   = r_note_out;
    assign bus.octave_out = r_octave_out;
    assign bus.busy       = (r_state != IDLE);
    assign bus.full       = r_full;
    assign bus.done       = r_done;
    assign bus.count      = r_count;

endmodule

// File: tb/tb_melody_recorder.sv
// Scoreboard bench for melody_recorder: random melodies recorded, then replayed and compared tick by tick.
module tb_melody_recorder;
    localparam int DEPTH = 4;
    localparam int DUR_W = 12;
    localparam int T     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    melody_recorder_if #(.DEPTH(DEPTH)) bus ();

    melody_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_code[$];
    int         seg_ticks[$];
    logic [7:0] ent_code[$];
    int         ent_dur[$];
    logic [7:0] q_code[$];
    int         q_done[$];
    bit         mon_play = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every playback tick shows one expected code; every done pulse ends one pass.
    always @(negedge clk) begin
        if (mon_play && bus.tick) begin
            if (q_code.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL play_extra_tick actual=%0d expected=none", {bus.note_out, bus.octave_out});
            end else begin
                chk("play_code", int'({bus.note_out, bus.octave_out}), int'(q_code.pop_front()));
            end
        end
        if (bus.done) begin
            if (q_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=1 expected=0");
            end else begin
                chk("done_timing", q_code.size(), q_done.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec();
        bus.rec = 1'b1; cyc(); bus.rec = 1'b0;
    endtask

    task automatic pulse_play();
        bus.play = 1'b1; cyc(); bus.play = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    endtask

    task automatic tick_wait();
        bus.tick = 1'b0;
        repeat (T - 1) cyc();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    // Model: each constant-code segment with at least one tick becomes one event, until the buffer fills.
    task automatic record();
        ent_code.delete();
        ent_dur.delete();
        {bus.note_in, bus.octave_in} = seg_code[0];
        pulse_rec();
        for (int i = 0; i < seg_code.size(); i++) begin
            if (i > 0) begin
                {bus.note_in, bus.octave_in} = seg_code[i];
                cyc();
                if (seg_ticks[i-1] > 0 && ent_code.size() < DEPTH) begin
                    ent_code.push_back(seg_code[i-1]);
                    ent_dur.push_back(seg_ticks[i-1]);
                    if (ent_code.size() == DEPTH) begin
                        chk("fill_full", bus.full, 1);
                        chk("fill_idle_busy", bus.busy, 0);
                    end
                end
            end
            repeat (seg_ticks[i]) tick_wait();
        end
        pulse_stop();
        if (seg_ticks[seg_ticks.size()-1] > 0 && ent_code.size() < DEPTH) begin
            ent_code.push_back(seg_code[seg_code.size()-1]);
            ent_dur.push_back(seg_ticks[seg_ticks.size()-1]);
        end
        cyc();
        chk("rec_count", bus.count, ent_code.size());
        chk("rec_full", bus.full, int'(ent_code.size() == DEPTH));
        chk("rec_busy", bus.busy, 0);
    endtask

    task automatic play_check(input bit inj_rec);
        int passes;
        int total;
`ifdef MELODY_LOOP_EN
        passes = 2;
`else
        passes = 1;
`endif
        total = 0;
        foreach (ent_dur[i]) total += ent_dur[i];
        if (ent_code.size() == 0) begin
            pulse_play();
            chk("play_empty_busy", bus.busy, 0);
        end else begin
            for (int p = 0; p < passes; p++) begin
                foreach (ent_code[i]) repeat (ent_dur[i]) q_code.push_back(ent_code[i]);
                q_done.push_back((passes - 1 - p) * total);
            end
            mon_play = 1'b1;
            pulse_play();
            for (int k = 0; k < total * passes; k++) begin
                tick_wait();
                if (inj_rec && k == 0) pulse_rec();
            end
            cyc();
            cyc();
`ifdef MELODY_LOOP_EN
            pulse_stop();
            cyc();
`endif
            mon_play = 1'b0;
            chk("play_drained", q_code.size() + q_done.size(), 0);
            chk("play_end_busy", bus.busy, 0);
            q_code.delete();
            q_done.delete();
        end
    endtask

    task automatic set_segs3(input logic [7:0] c0, input int t0, input logic [7:0] c1, input int t1,
                             input logic [7:0] c2, input int t2);
        seg_code.delete();
        seg_ticks.delete();
        seg_code.push_back(c0); seg_ticks.push_back(t0);
        seg_code.push_back(c1); seg_ticks.push_back(t1);
        seg_code.push_back(c2); seg_ticks.push_back(t2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        bus.tick = 0; bus.note_in = 0; bus.octave_in = 0;
        bus.rec = 0; bus.play = 0; bus.stop = 0;
        rst = 1'b1;
        bus.note_in = 4'd9;
        bus.octave_in = 4'd7;
        repeat (3) cyc();
        chk("rst_note", bus.note_out, 0);
        chk("rst_octave", bus.octave_out, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;

        bus.note_in = 4'd5;
        bus.octave_in = 4'd4;
        cyc();
        chk("pt_note", bus.note_out, 5);
        chk("pt_octave", bus.octave_out, 4);
        chk("pt_busy", bus.busy, 0);

        pulse_play();
        chk("play_empty_busy", bus.busy, 0);
        cyc();
        chk("play_empty_busy2", bus.busy, 0);

        set_segs3(8'h14, 3, 8'h34, 2, 8'h04, 1);
        record();
        chk("melody_count", bus.count, 3);
        play_check(1'b1);

        set_segs3(8'h23, 2, 8'h73, 0, 8'h25, 1);
        record();
        chk("drop_count", bus.count, 2);
        play_check(1'b0);

        set_segs3(8'h11, 1, 8'h21, 1, 8'h31, 1);
        seg_code.push_back(8'h41); seg_ticks.push_back(1);
        seg_code.push_back(8'h51); seg_ticks.push_back(1);
        record();
        chk("fill_count", bus.count, DEPTH);
        play_check(1'b0);

        pulse_play();
        cyc();
        chk("rs_in_play", bus.busy, 1);
        bus.rec = 1'b1;
        bus.stop = 1'b1;
        cyc();
        bus.rec = 1'b0;
        bus.stop = 1'b0;
        chk("rs_busy", bus.busy, 0);
        bus.note_in = 4'd9;
        bus.octave_in = 4'd2;
        cyc();
        chk("rs_live", int'({bus.note_out, bus.octave_out}), 8'h92);
        chk("rs_count", bus.count, DEPTH);

        pulse_play();
        cyc();
        rst = 1'b1;
        cyc();
        chk("rstplay_busy", bus.busy, 0);
        chk("rstplay_out", int'({bus.note_out, bus.octave_out}), 0);
        chk("rstplay_count", bus.count, 0);
        chk("rstplay_full", bus.full, 0);
        rst = 1'b0;
        cyc();

        for (int it = 0; it < 8; it++) begin
            int nseg;
            nseg = $urandom_range(2, 6);
            seg_code.delete();
            seg_ticks.delete();
            c = 8'($urandom_range(0, 255));
            for (int s = 0; s < nseg; s++) begin
                if (s > 0) begin
                    logic [7:0] n;
                    n = 8'($urandom_range(0, 255));
                    while (n == c) n = 8'($urandom_range(0, 255));
                    c = n;
                end
                seg_code.push_back(c);
                seg_ticks.push_back((s == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
            end
            record();
            play_check(it[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
